// File: rtl/lcd_char_feeder.sv
// rtl/lcd_char_feeder.sv - paced character FIFO that feeds the character LCD controller
//
// Purpose:
//   Buffers characters from a producer. Waits out the LCD power-on time after
//   reset, then issues one-cycle write strobes with a fixed idle gap between
//   them. The LCD controller has no busy output, so pacing is purely time-based.
//
// Ports:
//   Clock           system clock, all logic on posedge
//   Reset           synchronous active-high reset
//   iPush, iChar    enqueue iChar this cycle
//   oFull, oEmpty   registered FIFO occupancy flags
//   oOverflow       sticky, set by a push dropped while full
//   oWrite_Enabled  one-cycle write strobe to the LCD controller
//   oData           character presented with the strobe, held afterwards
//   oBusy           high while waiting for power-on or inside a write gap

module lcd_char_feeder #(
   parameter int DEPTH     = 16,
   parameter int INIT_WAIT = 1100000,
   parameter int CHAR_GAP  = 2100
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iPush,
   input  logic [7:0] iChar,
   output logic       oFull,
   output logic       oEmpty,
   output logic       oOverflow,
   output logic       oWrite_Enabled,
   output logic [7:0] oData,
   output logic       oBusy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [31:0]  INIT_LAST  = 32'(INIT_WAIT - 1);
   localparam logic [31:0]  GAP_LAST   = 32'(CHAR_GAP - 1);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_IDLE  = 2'd1,
      S_ISSUE = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t        state;
   logic [31:0]   delayCount;
   logic [7:0]    popData;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   count;
   logic [AW:0]   countNext;
   logic          doPop;
   logic          doPush;

   // The FSM pops only from S_IDLE and only when the registered count says
   // there is something to take.
   assign doPop  = (state == S_IDLE) && (count != '0);

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign doPush = iPush && ((count != FULL_COUNT) || doPop);

   always_comb begin
      countNext = count;
      if (doPush && !doPop) begin
         countNext = count + 1'b1;
      end else if (!doPush && doPop) begin
         countNext = count - 1'b1;
      end
   end

   // Storage needs no reset; reset only blocks the write.
   always_ff @(posedge Clock) begin
      if (!Reset && doPush) begin
         mem[wrPtr] <= iChar;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         count     <= '0;
         oFull     <= 1'b0;
         oEmpty    <= 1'b1;
         oOverflow <= 1'b0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         count  <= countNext;
         oFull  <= (countNext == FULL_COUNT);
         oEmpty <= (countNext == '0);
         if (iPush && !doPush) begin
            oOverflow <= 1'b1;
         end
      end
   end

   // Popped character is staged in popData during S_IDLE and presented on
   // oData together with the strobe at the S_ISSUE edge.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state          <= S_INIT;
         delayCount     <= '0;
         popData        <= 8'h00;
         oWrite_Enabled <= 1'b0;
         oData          <= 8'h00;
      end else begin
         case (state)
            S_INIT: begin
               oWrite_Enabled <= 1'b0;
               if (delayCount == INIT_LAST) begin
                  delayCount <= '0;
                  state      <= S_IDLE;
               end else begin
                  delayCount <= delayCount + 32'd1;
               end
            end
            S_IDLE: begin
               oWrite_Enabled <= 1'b0;
               if (doPop) begin
                  popData <= mem[rdPtr];
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               oWrite_Enabled <= 1'b1;
               oData          <= popData;
               delayCount     <= '0;
               state          <= S_GAP;
            end
            S_GAP: begin
               oWrite_Enabled <= 1'b0;
               if (delayCount == GAP_LAST) begin
                  delayCount <= '0;
                  state      <= S_IDLE;
               end else begin
                  delayCount <= delayCount + 32'd1;
               end
            end
            default: begin
               oWrite_Enabled <= 1'b0;
               delayCount     <= '0;
               state          <= S_INIT;
            end
         endcase
      end
   end

   assign oBusy = (state == S_INIT) || (state == S_GAP);

endmodule

// File: tb/tb_lcd_char_feeder.sv
// tb/tb_lcd_char_feeder.sv - directed self-checking bench for lcd_char_feeder

module tb_lcd_char_feeder;

   localparam int DEPTH     = 4;
   localparam int INIT_WAIT = 20;
   localparam int CHAR_GAP  = 5;
   localparam int PERIOD    = CHAR_GAP + 2;
   localparam int FIRST_PULSE = INIT_WAIT + 2;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       iPush;
   logic [7:0] iChar;
   logic       oFull;
   logic       oEmpty;
   logic       oOverflow;
   logic       oWrite_Enabled;
   logic [7:0] oData;
   logic       oBusy;

   int nCompared   = 0;
   int nMismatched = 0;
   int cycle       = 0;

   logic [7:0] gotData[$];
   int         gotCycle[$];

   lcd_char_feeder #(
      .DEPTH(DEPTH),
      .INIT_WAIT(INIT_WAIT),
      .CHAR_GAP(CHAR_GAP)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .iPush(iPush),
      .iChar(iChar),
      .oFull(oFull),
      .oEmpty(oEmpty),
      .oOverflow(oOverflow),
      .oWrite_Enabled(oWrite_Enabled),
      .oData(oData),
      .oBusy(oBusy)
   );

   always #5 Clock = ~Clock;

   // cycle = number of rising edges since Reset was last released
   always @(posedge Clock) begin
      if (Reset) cycle <= 0;
      else       cycle <= cycle + 1;
   end

   always @(negedge Clock) begin
      if (oWrite_Enabled) begin
         gotData.push_back(oData);
         gotCycle.push_back(cycle);
      end
   end

   task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic doReset();
      Reset = 1'b1;
      iPush = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      gotData.delete();
      gotCycle.delete();
   endtask

   task automatic pushChar(input logic [7:0] c);
      iPush = 1'b1;
      iChar = c;
      @(negedge Clock);
      iPush = 1'b0;
   endtask

   task automatic waitUntilCycle(input int target);
      while (cycle < target) @(negedge Clock);
   endtask

   initial begin
      int startEdge;
      int idleCycle;
      int pushed;
      logic [7:0] abc [3];
      logic [7:0] fill [4];

      Reset = 1'b1;
      iPush = 1'b0;
      iChar = 8'h00;
      abc  = '{8'h41, 8'h42, 8'h43};
      fill = '{8'h61, 8'h62, 8'h63, 8'h64};

      // ---- reset state
      doReset();
      checkValue("rst_empty", oEmpty, 1);
      checkValue("rst_full", oFull, 0);
      checkValue("rst_ovf", oOverflow, 0);
      checkValue("rst_we", oWrite_Enabled, 0);
      checkValue("rst_data", oData, 8'h00);
      checkValue("rst_busy", oBusy, 1);

      // ---- 1: single 'H' pushed at edge 3
      @(negedge Clock);
      @(negedge Clock);
      pushChar(8'h48);
      checkValue("t1_nonempty", oEmpty, 0);
      waitUntilCycle(40);
      checkValue("t1_npulse", gotData.size(), 1);
      if (gotData.size() == 1) begin
         checkValue("t1_data", gotData[0], 8'h48);
         checkValue("t1_when", gotCycle[0], FIRST_PULSE);
      end
      checkValue("t1_empty", oEmpty, 1);
      checkValue("t1_hold", oData, 8'h48);
      checkValue("t1_idle_busy", oBusy, 0);

      // ---- 2: "ABC" back to back after init
      gotData.delete();
      gotCycle.delete();
      startEdge = cycle + 1;
      for (int i = 0; i < 3; i++) pushChar(abc[i]);
      waitUntilCycle(startEdge + 30);
      checkValue("t2_npulse", gotData.size(), 3);
      if (gotData.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            checkValue($sformatf("t2_data%0d", i), gotData[i], abc[i]);
            checkValue($sformatf("t2_when%0d", i), gotCycle[i], startEdge + 2 + i * PERIOD);
         end
      end

      // ---- 3: five pushes during init, fifth dropped
      doReset();
      for (int i = 0; i < 4; i++) pushChar(fill[i]);
      checkValue("t3_full", oFull, 1);
      checkValue("t3_ovf_pre", oOverflow, 0);
      pushChar(8'h65);
      checkValue("t3_ovf", oOverflow, 1);
      checkValue("t3_full2", oFull, 1);
      waitUntilCycle(FIRST_PULSE + 4 * PERIOD + 5);
      checkValue("t3_npulse", gotData.size(), 4);
      if (gotData.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            checkValue($sformatf("t3_data%0d", i), gotData[i], fill[i]);
            checkValue($sformatf("t3_when%0d", i), gotCycle[i], FIRST_PULSE + i * PERIOD);
         end
      end
      checkValue("t3_ovf_sticky", oOverflow, 1);
      checkValue("t3_empty", oEmpty, 1);

      // ---- 4: push into a full FIFO in the same cycle as the pop
      doReset();
      for (int i = 0; i < 4; i++) pushChar(fill[i]);
      idleCycle = -1;
      for (int n = 0; n < 60; n++) begin
         if (!oBusy) begin
            idleCycle = cycle;
            break;
         end
         @(negedge Clock);
      end
      checkValue("t4_init_len", idleCycle, INIT_WAIT);
      checkValue("t4_full_idle", oFull, 1);
      pushChar(8'h5A);
      checkValue("t4_full_after", oFull, 1);
      checkValue("t4_ovf", oOverflow, 0);
      waitUntilCycle(FIRST_PULSE + 5 * PERIOD + 5);
      checkValue("t4_npulse", gotData.size(), 5);
      if (gotData.size() == 5) begin
         for (int i = 0; i < 4; i++)
            checkValue($sformatf("t4_data%0d", i), gotData[i], fill[i]);
         checkValue("t4_last", gotData[4], 8'h5A);
      end

      // ---- 5: ten characters through the FIFO across pointer wrap
      doReset();
      waitUntilCycle(INIT_WAIT + 1);
      pushed = 0;
      for (int n = 0; n < 300; n++) begin
         if (pushed < 10 && !oFull) begin
            iPush = 1'b1;
            iChar = 8'h30 + 8'(pushed);
            pushed++;
         end else begin
            iPush = 1'b0;
         end
         @(negedge Clock);
         if (gotData.size() >= 10) break;
      end
      iPush = 1'b0;
      checkValue("t5_npushed", pushed, 10);
      checkValue("t5_npulse", gotData.size(), 10);
      if (gotData.size() == 10) begin
         for (int i = 0; i < 10; i++)
            checkValue($sformatf("t5_data%0d", i), gotData[i], 8'h30 + i);
      end
      checkValue("t5_ovf", oOverflow, 0);

      // ---- 6: reset in S_GAP with two entries still queued
      doReset();
      for (int i = 0; i < 4; i++) pushChar(fill[i]);
      pushChar(8'h65);
      waitUntilCycle(FIRST_PULSE + PERIOD + 1);
      checkValue("t6_pre_npulse", gotData.size(), 2);
      checkValue("t6_pre_ovf", oOverflow, 1);
      checkValue("t6_pre_empty", oEmpty, 0);
      checkValue("t6_pre_busy", oBusy, 1);
      Reset = 1'b1;
      @(negedge Clock);
      checkValue("t6_we", oWrite_Enabled, 0);
      checkValue("t6_empty", oEmpty, 1);
      checkValue("t6_ovf", oOverflow, 0);
      checkValue("t6_full", oFull, 0);
      checkValue("t6_data", oData, 8'h00);
      Reset = 1'b0;
      gotData.delete();
      gotCycle.delete();
      pushChar(8'h58);
      waitUntilCycle(FIRST_PULSE + 2 * PERIOD);
      checkValue("t6_npulse", gotData.size(), 1);
      if (gotData.size() == 1) begin
         checkValue("t6_post_data", gotData[0], 8'h58);
         checkValue("t6_post_when", gotCycle[0], FIRST_PULSE);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
